// File: rtl/temp_spi_scan.sv
// Purpose: round-robin SPI reader for N_CH temperature sensors; each channel's frame lands in its own temp_data slice.
// Latency: an accepted trigger opens channel 0 next cycle; scan_done pulses N_CH*CLK_DIV*(2*DATA_W+2)+1 cycles after acceptance.
// Backpressure: none; triggers arriving mid-scan merge into one pending rescan that starts right after DONE.
module temp_spi_scan #(
    parameter int N_CH        = 3,
    parameter int DATA_W      = 16,
    parameter int CLK_DIV     = 4,
    parameter int SCAN_PERIOD = 16000
) (
    input  logic                   fab_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   temp_so,
    output logic                   temp_sck,
    output logic [N_CH-1:0]        temp_csn,
    output logic [N_CH*DATA_W-1:0] temp_data,
    output logic [N_CH-1:0]        data_valid,
    output logic                   busy,
    output logic                   scan_done,
    output logic [31:0]            scan_count
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam int TMR_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SCAN_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [CH_W-1:0]  ch;
    logic [DATA_W-1:0] shift_reg;
    logic [TMR_W-1:0] tmr;
    logic             pend_start;
    logic             pend_tmr;

    logic             tmr_exp;
    logic             trig;
    logic             scan_go;
    logic             div_last;
    logic             in_scan;
    logic [CH_W-1:0]  ch_nxt;

    // A timer-only pending request is void once enable drops, even before the flop clears it.
    assign tmr_exp  = enable & (tmr == '0);
    assign trig     = start | tmr_exp | pend_start | (pend_tmr & enable);
    assign in_scan  = (state != IDLE);
    assign scan_go  = trig & ((state == IDLE) | (state == DONE));
    assign div_last = (div_cnt == DIV_LAST);
    assign ch_nxt   = ch + CH_W'(1);

    // Period timer: held while disabled, reloaded on every scan start, parks at zero until consumed.
    always_ff @(posedge fab_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= TMR_LOAD;
        end else if (!enable || scan_go) begin
            tmr <= TMR_LOAD;
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    // Pending flag, split by source so a disabled timer can withdraw its own request.
    always_ff @(posedge fab_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_start <= 1'b0;
            pend_tmr   <= 1'b0;
        end else if (scan_go) begin
            pend_start <= 1'b0;
            pend_tmr   <= 1'b0;
        end else begin
            if (start && in_scan) begin
                pend_start <= 1'b1;
            end
            pend_tmr <= enable & (pend_tmr | (tmr_exp & in_scan));
        end
    end

    // Scan sequencer: chip-select setup, bit shifting, inter-channel gap and scan completion.
    always_ff @(posedge fab_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= '0;
            ch         <= '0;
            shift_reg  <= '0;
            temp_sck   <= 1'b0;
            temp_csn   <= '1;
            temp_data  <= '0;
            data_valid <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            scan_count <= 32'd0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_go) begin
                        state    <= CS_SETUP;
                        ch       <= '0;
                        div_cnt  <= 8'd0;
                        temp_csn <= ~(N_CH'(1));
                        busy     <= 1'b1;
                    end
                end

                CS_SETUP: begin
                    if (div_last) begin
                        state   <= SHIFT;
                        div_cnt <= 8'd0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!temp_sck) begin
                            // Rising SCK edge: capture the sensor bit, MSB first.
                            temp_sck  <= 1'b1;
                            shift_reg <= {shift_reg[DATA_W-2:0], temp_so};
                        end else if (bit_cnt == BIT_LAST) begin
                            // Frame complete: close the channel and publish the whole word at once.
                            temp_sck   <= 1'b0;
                            temp_csn   <= '1;
                            temp_data[ch*DATA_W +: DATA_W] <= shift_reg;
                            data_valid[ch] <= 1'b1;
                            state      <= GAP;
                        end else begin
                            temp_sck <= 1'b0;
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                GAP: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (ch == CH_LAST) begin
                            state      <= DONE;
                            scan_done  <= 1'b1;
                            scan_count <= scan_count + 32'd1;
                        end else begin
                            ch       <= ch_nxt;
                            temp_csn <= ~(N_CH'(1) << ch_nxt);
                            state    <= CS_SETUP;
                        end
                    end
                end

                DONE: begin
                    if (scan_go) begin
                        // A merged request restarts immediately without passing through IDLE.
                        state    <= CS_SETUP;
                        ch       <= '0;
                        div_cnt  <= 8'd0;
                        temp_csn <= ~(N_CH'(1));
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    temp_sck <= 1'b0;
                    temp_csn <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_spi_scan.sv
// Purpose: directed checks of temp_spi_scan with a mode-0 sensor model and a bus protocol monitor.
// Latency: cycle numbers are relative to the cycle in which start is driven (cycle 0).
// Backpressure: not applicable; the bench drives start/enable/rst_n directly.
module tb_temp_spi_scan;

    localparam int N_CH        = 3;
    localparam int DATA_W      = 16;
    localparam int CLK_DIV     = 2;
    localparam int SCAN_PERIOD = 300;

    logic                   fab_clk = 1'b0;
    logic                   rst_n   = 1'b0;
    logic                   enable  = 1'b0;
    logic                   start   = 1'b0;
    logic                   temp_so;
    logic                   temp_sck;
    logic [N_CH-1:0]        temp_csn;
    logic [N_CH*DATA_W-1:0] temp_data;
    logic [N_CH-1:0]        data_valid;
    logic                   busy;
    logic                   scan_done;
    logic [31:0]            scan_count;

    int n_vec = 0;
    int n_err = 0;
    int at;
    int prev_at;

    temp_spi_scan #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .SCAN_PERIOD(SCAN_PERIOD)
    ) dut (
        .fab_clk(fab_clk), .rst_n(rst_n), .enable(enable), .start(start),
        .temp_so(temp_so), .temp_sck(temp_sck), .temp_csn(temp_csn),
        .temp_data(temp_data), .data_valid(data_valid), .busy(busy),
        .scan_done(scan_done), .scan_count(scan_count)
    );

    always #5 fab_clk = ~fab_clk;

    // Sensor model: MSB presented when selected, next bit after each falling SCK.
    logic [DATA_W-1:0] sens [N_CH];
    int                so_idx   = DATA_W - 1;
    logic [N_CH-1:0]   so_csn_q = '1;
    logic              so_sck_q = 1'b0;

    always @(temp_csn or temp_sck) begin
        if (temp_csn != so_csn_q) so_idx = DATA_W - 1;
        else if (!temp_sck && so_sck_q && so_idx > 0) so_idx = so_idx - 1;
        so_csn_q = temp_csn;
        so_sck_q = temp_sck;
    end

    always_comb begin
        temp_so = 1'b0;
        for (int k = 0; k < N_CH; k++) if (!temp_csn[k]) temp_so = sens[k][so_idx];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge fab_clk);
        #1;
    endtask

    // Called at the cycle-0 sample point; returns at the cycle-1 sample point.
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (scan_done) begin
                cyc = from + i;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_busy(input int from, input int budget, output int cyc);
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy) begin
                cyc = from + i;
                break;
            end
            tick(1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Protocol monitor: one low chip select, SCK low at every select edge, DATA_W rises per frame,
    // temp_data only changes at a frame end.
    logic [N_CH-1:0]        m_csn;
    logic                   m_sck;
    logic [N_CH*DATA_W-1:0] m_data;
    int                     m_rises = 0;
    logic                   m_armed = 1'b0;

    always @(negedge fab_clk) begin
        if (!rst_n) begin
            m_rises = 0;
            m_armed = 1'b0;
        end else if (m_armed) begin
            if (temp_sck && !m_sck) m_rises++;
            if (temp_csn != m_csn) begin
                chk("csn_at_most_one_low", 64'($countones(~temp_csn) <= 1), 64'd1);
                chk("sck_low_at_csn_edge", 64'(temp_sck), 64'd0);
            end
            if (temp_data != m_data)
                chk("data_only_at_frame_end", 64'((&temp_csn) && !(&m_csn)), 64'd1);
            if ((&temp_csn) && !(&m_csn)) begin
                chk("sck_rises_per_frame", 64'(m_rises), 64'(DATA_W));
                m_rises = 0;
            end
            if (!(&temp_csn) && (&m_csn)) m_rises = 0;
        end else begin
            m_armed = 1'b1;
        end
        m_csn  = temp_csn;
        m_sck  = temp_sck;
        m_data = temp_data;
    end

    typedef struct {
        logic [15:0] f0;
        logic [15:0] f1;
        logic [15:0] f2;
        logic [47:0] exp_data;
        logic [31:0] exp_count;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{16'h1234, 16'hABCD, 16'h8001, 48'h8001_ABCD_1234, 32'd1};
        tbl[1] = '{16'hFFFF, 16'h0000, 16'h5A5A, 48'h5A5A_0000_FFFF, 32'd2};
        tbl[2] = '{16'h0001, 16'h8000, 16'hC3C3, 48'hC3C3_8000_0001, 32'd3};
        tbl[3] = '{16'h0000, 16'hFFFF, 16'h1357, 48'h1357_FFFF_0000, 32'd4};
        sens[0] = '0; sens[1] = '0; sens[2] = '0;

        // Reset state.
        do_reset();
        chk("rst_csn", 64'(temp_csn), 64'h7);
        chk("rst_sck", 64'(temp_sck), 64'h0);
        chk("rst_data", 64'(temp_data), 64'h0);
        chk("rst_valid", 64'(data_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(scan_done), 64'h0);
        chk("rst_count", 64'(scan_count), 64'h0);

        // Table-driven back-to-back scans.
        for (int i = 0; i < 4; i++) begin
            sens[0] = tbl[i].f0; sens[1] = tbl[i].f1; sens[2] = tbl[i].f2;
            pulse_start();
            chk("csn0_low_cycle1", 64'(temp_csn), 64'h6);
            chk("busy_cycle1", 64'(busy), 64'h1);
            wait_done(1, 400, at);
            chk("done_cycle", 64'(at), 64'd205);
            chk("scan_data", 64'(temp_data), 64'(tbl[i].exp_data));
            chk("scan_valid", 64'(data_valid), 64'h7);
            chk("scan_count", 64'(scan_count), 64'(tbl[i].exp_count));
            tick(1);
            chk("idle_after_done", 64'(busy), 64'h0);
            chk("done_one_cycle", 64'(scan_done), 64'h0);
        end

        // Reset during channel 0 SHIFT, then a clean scan.
        do_reset();
        sens[0] = 16'h1234; sens[1] = 16'hABCD; sens[2] = 16'h8001;
        pulse_start();
        wait_done(1, 400, at);
        tick(1);
        pulse_start();
        tick(39);
        rst_n = 1'b0;
        #1;
        chk("midrst_csn", 64'(temp_csn), 64'h7);
        chk("midrst_sck", 64'(temp_sck), 64'h0);
        chk("midrst_valid", 64'(data_valid), 64'h0);
        chk("midrst_data", 64'(temp_data), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_count", 64'(scan_count), 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        sens[0] = 16'h0F0F; sens[1] = 16'h7E57; sens[2] = 16'h2468;
        pulse_start();
        tick(67);
        chk("partial_valid_c68", 64'(data_valid), 64'h1);
        chk("partial_data_c68", 64'(temp_data), 64'h0000_0000_0F0F);
        wait_done(68, 300, at);
        chk("postrst_done_cycle", 64'(at), 64'd205);
        chk("postrst_data", 64'(temp_data), 64'h2468_7E57_0F0F);
        chk("postrst_count", 64'(scan_count), 64'd1);
        tick(1);

        // Two starts during a scan merge into exactly one follow-on scan.
        do_reset();
        sens[0] = 16'h1234; sens[1] = 16'hABCD; sens[2] = 16'h8001;
        pulse_start();
        tick(49);
        pulse_start();
        tick(49);
        pulse_start();
        wait_done(101, 300, at);
        chk("merge_first_done", 64'(at), 64'd205);
        tick(1);
        chk("merge_restart_busy", 64'(busy), 64'h1);
        chk("merge_restart_csn", 64'(temp_csn), 64'h6);
        wait_done(206, 300, at);
        chk("merge_second_done", 64'(at), 64'd410);
        chk("merge_count", 64'(scan_count), 64'd2);
        tick(1);
        wait_done(411, 300, at);
        chk("merge_no_third_scan", 64'(at), 64'(-1));
        chk("merge_count_final", 64'(scan_count), 64'd2);

        // Periodic scanning every SCAN_PERIOD cycles, stopping when enable drops.
        do_reset();
        enable = 1'b1;
        pulse_start();
        chk("periodic_start1", 64'(busy), 64'h1);
        wait_done(1, 400, at);
        chk("periodic_done1", 64'(at), 64'd205);
        prev_at = at;
        tick(1);
        wait_busy(206, 400, at);
        chk("periodic_start2", 64'(at), 64'd301);
        wait_done(at, 400, at);
        chk("periodic_spacing1", 64'(at - prev_at), 64'd300);
        prev_at = at;
        tick(1);
        wait_busy(prev_at + 1, 400, at);
        chk("periodic_start3", 64'(at), 64'd601);
        wait_done(at, 400, at);
        chk("periodic_spacing2", 64'(at - prev_at), 64'd300);
        enable = 1'b0;
        tick(1);
        wait_busy(0, 700, at);
        chk("disabled_no_scan", 64'(at), 64'(-1));
        chk("periodic_count", 64'(scan_count), 64'd3);

        // scan_count wraps from all-ones to zero.
        do_reset();
        tick(2);
        force dut.scan_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.scan_count;
        tick(1);
        chk("wrap_preload", 64'(scan_count), 64'hFFFF_FFFF);
        pulse_start();
        wait_done(1, 400, at);
        chk("wrap_done_cycle", 64'(at), 64'd205);
        chk("wrap_count", 64'(scan_count), 64'h0);
        tick(1);
        chk("wrap_done_width", 64'(scan_done), 64'h0);
        wait_done(206, 300, at);
        chk("wrap_single_pulse", 64'(at), 64'(-1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
